// File: rtl/startup_seq_pkg.sv
// rtl/startup_seq_pkg.sv - shared state encoding and default phase table for the startup sequencer
package startup_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam logic [7:0] CMD_BIST   = 8'h52;
  localparam logic [7:0] CMD_CONFIG = 8'h53;
  localparam logic [7:0] CMD_LOAD   = 8'h54;

  // Phase 0 = BIST, phase 1 = BSG handshake, phase 2 = config, phase 3 = load
  localparam logic [31:0] DEFAULT_PHASE_CMDS     = {CMD_LOAD, CMD_CONFIG, 8'h00, CMD_BIST};
  localparam logic [3:0]  DEFAULT_PHASE_BSG_MASK = 4'b0010;

endpackage

// File: rtl/startup_timeout_timer.sv
// rtl/startup_timeout_timer.sv - saturating WAIT-state cycle counter with expiry flag
module startup_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (count_en && (cnt != W'(TIMEOUT_CYCLES))) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Flags the cycle whose count step would reach TIMEOUT_CYCLES
  assign expired = count_en && (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/startup_sequencer.sv
// rtl/startup_sequencer.sv - ordered startup phase walker; optional WAIT timeout under STARTUP_TIMEOUT_EN
module startup_sequencer
  import startup_seq_pkg::*;
#(
  parameter int                         NUM_PHASES     = 4,
  parameter int                         DATA_W         = 8,
  parameter int                         CMD_REPEAT     = 3,
  parameter logic [NUM_PHASES*DATA_W-1:0] PHASE_CMDS   = DEFAULT_PHASE_CMDS,
  parameter logic [NUM_PHASES-1:0]      PHASE_BSG_MASK = DEFAULT_PHASE_BSG_MASK,
  parameter int                         TIMEOUT_CYCLES = 1024,
  localparam int                        PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NUM_PHASES-1:0] phase_done,
  input  logic                  ready_a,
  output logic                  valid_a,
  output logic [DATA_W-1:0]     data_a,
  output logic                  bsg_enable,
  output logic                  select_signal,
  output logic [PW-1:0]         phase_idx,
  output logic                  startup_done,
  output logic                  error
);

  localparam int            CW        = $clog2(CMD_REPEAT + 1);
  localparam logic [CW-1:0] BEAT_LAST = CW'(CMD_REPEAT - 1);
  localparam logic [PW-1:0] LAST_PH   = PW'(NUM_PHASES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [PW-1:0] phase_d;
  logic          xfer;
  logic          timeout;

  function automatic state_t entry_state(input logic [PW-1:0] p);
    return PHASE_BSG_MASK[p] ? WAIT : SEND;
  endfunction

  function automatic logic [DATA_W-1:0] cmd_of(input logic [PW-1:0] p);
    logic [DATA_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (p == PW'(i)) c = PHASE_CMDS[i*DATA_W +: DATA_W];
    end
    return c;
  endfunction

  assign xfer = valid_a && ready_a;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    phase_d = phase_idx;
    case (state_q)
      IDLE: begin
        if (enable) begin
          phase_d = '0;
          state_d = entry_state('0);
        end
      end
      SEND: begin
        // An abort only takes effect once the in-flight beat has been accepted
        if (xfer) begin
          if (!enable) begin
            state_d = IDLE;
            beat_d  = '0;
            phase_d = '0;
          end else if (beat_q == BEAT_LAST) begin
            state_d = WAIT;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
          phase_d = '0;
        end else if (phase_done[phase_idx]) begin
          if (phase_idx == LAST_PH) begin
            state_d = DONE;
            phase_d = '0;
          end else begin
            phase_d = phase_idx + 1'b1;
            state_d = entry_state(phase_idx + 1'b1);
          end
        end else if (timeout) begin
          state_d = ERROR;
          phase_d = '0;
        end
      end
      DONE, ERROR: begin
        if (!enable) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
        phase_d = '0;
      end
    endcase
  end

`ifdef STARTUP_TIMEOUT_EN
  logic wait_clear;

  // Restart the count on every WAIT entry, including BSG-to-BSG phase advances
  assign wait_clear = (state_d == WAIT) && ((state_q != WAIT) || (phase_d != phase_idx));

  startup_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear),
    .count_en(state_q == WAIT),
    .expired (timeout)
  );
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign error              = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      phase_idx     <= '0;
      valid_a       <= 1'b0;
      data_a        <= '0;
      bsg_enable    <= 1'b0;
      select_signal <= 1'b0;
      startup_done  <= 1'b0;
`ifdef STARTUP_TIMEOUT_EN
      error         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      phase_idx     <= phase_d;
      valid_a       <= (state_d == SEND);
      data_a        <= (state_d == SEND) ? cmd_of(phase_d) : '0;
      bsg_enable    <= (state_d == WAIT) && PHASE_BSG_MASK[phase_d];
      select_signal <= (state_d == WAIT) && PHASE_BSG_MASK[phase_d];
      startup_done  <= (state_d == DONE);
`ifdef STARTUP_TIMEOUT_EN
      error         <= (state_d == ERROR);
`endif
    end
  end

endmodule

// File: tb/tb_startup_sequencer.sv
// tb/tb_startup_sequencer.sv - directed scoreboard bench for startup_sequencer
module tb_startup_sequencer;

  localparam logic [7:0] C_BIST = 8'h52;
  localparam logic [7:0] C_CFG  = 8'h53;
  localparam logic [7:0] C_LOAD = 8'h54;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] phase_done;
  logic       ready_a;
  logic       valid_a;
  logic [7:0] data_a;
  logic       bsg_enable;
  logic       select_signal;
  logic [1:0] phase_idx;
  logic       startup_done;
  logic       error;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         n_xfer   = 0;
  int         base;
  logic [7:0] exp_q[$];
  logic       pat[6];

  always #5 clk = ~clk;

  startup_sequencer #(
    .NUM_PHASES    (4),
    .DATA_W        (8),
    .CMD_REPEAT    (3),
    .PHASE_CMDS    (32'h5453_0052),
    .PHASE_BSG_MASK(4'b0010),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .phase_done   (phase_done),
    .ready_a      (ready_a),
    .valid_a      (valid_a),
    .data_a       (data_a),
    .bsg_enable   (bsg_enable),
    .select_signal(select_signal),
    .phase_idx    (phase_idx),
    .startup_done (startup_done),
    .error        (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] all_outs();
    return {valid_a, data_a, bsg_enable, select_signal, phase_idx, startup_done, error};
  endfunction

  // Inputs are stable here, so valid_a && ready_a is exactly what the next posedge sees
  task automatic cyc();
    logic [7:0] e;
    if (valid_a && ready_a) begin
      n_xfer++;
      check("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("beat_data", data_a, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic send_phase(input logic [1:0] p, input logic [7:0] cmd);
    for (int i = 0; i < 3; i++) exp_q.push_back(cmd);
    check("send_phase_idx", phase_idx, p);
    for (int i = 0; i < 3; i++) begin
      check("beat_valid", valid_a, 1);
      cyc();
    end
    check("send_end_valid", valid_a, 0);
    check("send_end_data", data_a, 0);
  endtask

  task automatic pulse_done(input int p);
    cyc();
    phase_done[p] = 1'b1;
    cyc();
    phase_done = '0;
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    phase_done = '0;
    ready_a    = 1'b0;
    @(negedge clk);
    cyc();
    rst = 1'b0;
    check("reset_outs", all_outs(), 0);
    cyc();
    check("idle_outs", all_outs(), 0);

    // Nominal run
    ready_a = 1'b1;
    enable  = 1'b1;
    cyc();
    check("first_valid", valid_a, 1);
    send_phase(2'd0, C_BIST);
    check("ph0_wait_bsg", bsg_enable, 0);
    pulse_done(0);
    check("ph1_bsg", bsg_enable, 1);
    check("ph1_sel", select_signal, 1);
    check("ph1_idx", phase_idx, 1);
    check("ph1_valid", valid_a, 0);
    cyc();
    check("ph1_bsg_hold", bsg_enable, 1);
    pulse_done(1);
    check("ph2_bsg_off", bsg_enable, 0);
    send_phase(2'd2, C_CFG);
    pulse_done(2);
    send_phase(2'd3, C_LOAD);
    check("ph3_not_done", startup_done, 0);
    pulse_done(3);
    check("startup_done", all_outs(), 15'h0002);
    cyc();
    cyc();
    check("done_hold", startup_done, 1);
    enable = 1'b0;
    cyc();
    check("done_clear", all_outs(), 0);

    // Backpressure with early done in SEND, then foreign done in WAIT
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ready_a = 1'b0;
    enable  = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) exp_q.push_back(C_BIST);
    base       = n_xfer;
    phase_done = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      ready_a = pat[i];
      check("bp_valid", valid_a, 1);
      check("bp_data", data_a, C_BIST);
      cyc();
    end
    check("bp_xfers", n_xfer - base, 3);
    check("bp_wait_valid", valid_a, 0);
    phase_done = 4'b0100;
    cyc();
    cyc();
    check("foreign_done_idx", phase_idx, 0);
    check("foreign_done_bsg", bsg_enable, 0);
    phase_done = 4'b0001;
    cyc();
    phase_done = '0;
    check("adv_idx", phase_idx, 1);
    check("adv_bsg", bsg_enable, 1);
    enable = 1'b0;
    cyc();
    check("abort_wait", all_outs(), 0);

    // Abort with a beat pending
    ready_a = 1'b0;
    enable  = 1'b1;
    cyc();
    exp_q.push_back(C_BIST);
    base   = n_xfer;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("pend_valid", valid_a, 1);
      check("pend_data", data_a, C_BIST);
      cyc();
    end
    ready_a = 1'b1;
    cyc();
    check("abort_xfers", n_xfer - base, 1);
    check("abort_idle", all_outs(), 0);
    cyc();
    check("abort_idle_hold", all_outs(), 0);
    enable = 1'b1;
    cyc();
    check("reenable_idx", phase_idx, 0);
    check("reenable_data", data_a, C_BIST);

    // Reset during phase-2 SEND
    send_phase(2'd0, C_BIST);
    pulse_done(0);
    ready_a = 1'b0;
    pulse_done(1);
    check("ph2_idx", phase_idx, 2);
    check("ph2_data", data_a, C_CFG);
    cyc();
    check("ph2_stall", valid_a, 1);
    rst = 1'b1;
    cyc();
    rst    = 1'b0;
    enable = 1'b0;
    check("midreset_outs", all_outs(), 0);
    cyc();
    check("midreset_idle", all_outs(), 0);

    // WAIT with no done: times out only when the feature is built in
    ready_a = 1'b1;
    enable  = 1'b1;
    cyc();
    send_phase(2'd0, C_BIST);
    repeat (15) cyc();
    check("pre_timeout_err", error, 0);
    cyc();
`ifdef STARTUP_TIMEOUT_EN
    check("timeout_err", all_outs(), 15'h0001);
`else
    check("no_timeout_err", error, 0);
    check("no_timeout_idx", phase_idx, 0);
    repeat (20) cyc();
    check("still_waiting", all_outs(), 0);
`endif
    enable = 1'b0;
    cyc();
    check("err_clear", all_outs(), 0);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
